// File: rtl/step_run_pkg.sv
// Shared definitions for the step/run front-end: debounce filter states and defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package step_run_pkg;

   // Debounce filter states. WAIT_x means "seeing x, not yet accepted".
   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      WAIT_HI   = 2'd1,
      STABLE_HI = 2'd2,
      WAIT_LO   = 2'd3
   } filt_state_t;

   // One million cycles of stability, i.e. a few ms at typical board clocks.
   localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

endpackage

// File: rtl/db_filter.sv
// Two-flop synchroniser followed by a debounce FSM with a saturating stability counter.
// Latency: a clean raw edge reaches level after 2+DEBOUNCE_CYCLES rising edges.
// Backpressure: none; the input is sampled every cycle.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   raw    raw input, asynchronous to clk
//   level  debounced, registered level
module db_filter
   import step_run_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
   // With a one-cycle requirement the first differing sample already qualifies.
   localparam bit ONE_SHOT = (DEBOUNCE_CYCLES == 1);

   logic            sync1;
   logic            sync2;
   filt_state_t     state;
   filt_state_t     state_nxt;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_nxt;
   logic [CW-1:0]   cnt_inc;
   logic            level_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Saturating increment so the counter can never wrap back below the threshold.
   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      level_nxt = level;
      case (state)
         STABLE_LO: begin
            if (sync2) begin
               if (ONE_SHOT) begin
                  state_nxt = STABLE_HI;
                  level_nxt = 1'b1;
               end else begin
                  state_nxt = WAIT_HI;
                  cnt_nxt   = CW'(1);
               end
            end
         end
         WAIT_HI: begin
            if (sync2) begin
               if (cnt_inc == CNT_MAX) begin
                  state_nxt = STABLE_HI;
                  level_nxt = 1'b1;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end else begin
               state_nxt = STABLE_LO;
               cnt_nxt   = '0;
            end
         end
         STABLE_HI: begin
            if (!sync2) begin
               if (ONE_SHOT) begin
                  state_nxt = STABLE_LO;
                  level_nxt = 1'b0;
               end else begin
                  state_nxt = WAIT_LO;
                  cnt_nxt   = CW'(1);
               end
            end
         end
         WAIT_LO: begin
            if (!sync2) begin
               if (cnt_inc == CNT_MAX) begin
                  state_nxt = STABLE_LO;
                  level_nxt = 1'b0;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end else begin
               state_nxt = STABLE_HI;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = STABLE_LO;
            cnt_nxt   = '0;
            level_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= STABLE_LO;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         level <= level_nxt;
      end
   end

endmodule

// File: rtl/step_run_ctrl.sv
// Board-control front-end producing cont/run for the multicycle control FSM, plus step pulse/count.
// Latency: raw edge to cont/run is 2+DEBOUNCE_CYCLES edges; step_pulse one cycle after the filtered rise.
// Backpressure: none; inputs are free-running switch levels.
//
// Build option: define STEP_TOGGLE_EN to make run toggle once per press instead of
// following the debounced button level.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   sw_cont     raw free-run switch
//   btn_step    raw step push-button, active-high
//   cont        debounced free-run level
//   run         step level; each change requests one instruction
//   step_pulse  one-cycle pulse per accepted press
//   step_count  accepted presses, wrapping
module step_run_ctrl
   import step_run_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int STEP_CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sw_cont,
   input  logic                  btn_step,
   output logic                  cont,
   output logic                  run,
   output logic                  step_pulse,
   output logic [STEP_CNT_W-1:0] step_count
);

   logic btn_lvl;
   logic btn_lvl_q;

   db_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cont_filt (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (sw_cont),
      .level (cont)
   );

   db_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_filt (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_step),
      .level (btn_lvl)
   );

   // Rising edge of the filtered button becomes a registered single-cycle pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_lvl_q  <= 1'b0;
         step_pulse <= 1'b0;
         step_count <= '0;
      end else begin
         btn_lvl_q  <= btn_lvl;
         step_pulse <= btn_lvl & ~btn_lvl_q;
         if (step_pulse) begin
            step_count <= step_count + 1'b1;
         end
      end
   end

`ifdef STEP_TOGGLE_EN
   logic run_q;

   // One full press/release cycle yields a single run transition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q <= 1'b0;
      end else if (step_pulse) begin
         run_q <= ~run_q;
      end
   end

   assign run = run_q;
`else
   assign run = btn_lvl;
`endif

endmodule

// File: doc/step_run_ctrl.md
Name: step_run_ctrl

Overview:
- Upstream front-end for the multicycle control FSM. It produces that FSM's `cont` (free-run) and `run` (single-step) inputs from board controls.
- Synchronises and debounces the raw switch and push-button, so each physical step press is seen as exactly one clean level change.
- Provides a step pulse and a wrapping step counter for the display/debug path.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable clock cycles needed to accept a new input level (min 1).
- STEP_CNT_W, 16, width of the step press counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sw_cont  input  1  raw free-run switch, asynchronous to clk.
- btn_step  input  1  raw step push-button, asynchronous to clk, active-high.
- cont  output  1  debounced free-run level to the control FSM.
- run  output  1  step level to the control FSM; each level change requests one instruction.
- step_pulse  output  1  one-cycle pulse per accepted step press.
- step_count  output  STEP_CNT_W  accepted step presses, modulo 2^STEP_CNT_W.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values:
  - cont=0, run=0, step_pulse=0, step_count=0.
  - All synchroniser flops, filter states and counters are cleared.
  - cont=0 with run=0 holds the downstream FSM parked in its idle-ready state.
- Synchroniser: each raw input passes through 2 flops before any logic.
- Debounce filter, one instance per input; states STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO:
  - STABLE_x: if the synced value differs from x, go to WAIT_(not x) with the counter at 1.
  - WAIT_y: if the synced value equals y, increment the counter. When the counter reaches DEBOUNCE_CYCLES, go to STABLE_y and update the filtered level on that edge.
  - WAIT_y: if the synced value reverts, return to STABLE_(not y) and clear the counter. Glitches shorter than DEBOUNCE_CYCLES never reach the outputs.
  - Counter width is clog2(DEBOUNCE_CYCLES+1) and it saturates.
- Latency: from a clean raw edge to the filtered level changing is 2+DEBOUNCE_CYCLES rising edges.
- cont = filtered sw_cont, registered.
- run = filtered btn_step (press and release each toggle the level).
- step_pulse is high for exactly one cycle, the cycle after the filtered btn_step rises 0->1. Releases do not pulse.
- step_count increments on each step_pulse and wraps from 2^STEP_CNT_W-1 to 0.
- The two inputs are fully independent; simultaneous changes are filtered in parallel with no interaction.
- Step presses are counted regardless of the cont level.
- Reset mid-debounce or mid-press:
  - Filters restart at STABLE_LO.
  - A button still held after reset release is accepted as a new press after the full latency, producing one step_pulse and a count of 1.
  - A switch still high after reset release raises cont after the full latency.

Optional Feature:
- Macro: STEP_TOGGLE_EN.
- Defined: run is a toggle flop that inverts on each step_pulse. One press (press plus release) gives exactly one run level change, i.e. one instruction. Releases have no effect on run.
- Undefined: run follows the filtered button level directly, as described above. Press and release each step one instruction.
- step_pulse and step_count behave identically in both builds.

Decomposition:
- Shared package step_run_pkg holds:
  - the 2-bit filter state encoding (STABLE_LO=0, WAIT_HI=1, STABLE_HI=2, WAIT_LO=3);
  - the default DEBOUNCE_CYCLES constant.
- Sub-module db_filter: synchroniser plus debounce FSM.
  - Parameter: DEBOUNCE_CYCLES.
  - Ports: clk, rst_n, raw, level.
  - Instantiated twice; edge detection, toggle and counter live in the top module.

Test Plan (DEBOUNCE_CYCLES=4, STEP_CNT_W=4):
- Reset with btn_step=0, sw_cont=0 -> all outputs 0. Hold 20 cycles -> no change.
- btn_step 0->1, held clean -> run=1 exactly 6 edges later; step_pulse high one cycle; step_count=1.
- btn_step 3-cycle glitch high, then low -> run, step_pulse and step_count unchanged. Bouncing 1,0,1,0 then steady 1 -> exactly one step_pulse.
- 16 clean presses -> step_count goes 1..15 then 0; 16 step_pulses, each one cycle wide.
- sw_cont=1 while a step press occurs -> cont=1 after 6 edges, and step_count still increments.
- STEP_TOGGLE_EN build: press then release, twice -> run goes 0->1 on the first press, stays 1 on release, goes to 0 on the second press. Assert rst_n low mid-WAIT_HI -> outputs 0 immediately.
